vga_frame_reader: RTL and testbench

- Display-side consumer of the dual-port pixel RAM that the CPU writes through port A.
- Generates 640x480@60 VGA timing on vga_clk and drives port B read addresses for a 256x256 8-bit image placed inside the active area.
- Outputs grayscale RGB with hsync/vsync/blank aligned to the RAM read latency.
- Sits between the pixel RAM port B and the board VGA DAC; the RAM port B address/data connections are owned solely by this block.

---
 rtl/vga_frame_reader.sv | 124 ++++++++++++
 tb/tb_vga_frame_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - 640x480 VGA timing and pixel RAM port B reader
// Shows a 256x256 8-bit grayscale image at (X_OFF, Y_OFF) inside the active area.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int X_OFF    = 192,
    parameter int Y_OFF    = 112,
    parameter int RD_LAT   = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_FIRST  = 10'(X_OFF);
    localparam logic [9:0] X_LAST   = 10'(X_OFF + 255);
    localparam logic [9:0] Y_FIRST  = 10'(Y_OFF);
    localparam logic [9:0] Y_LAST   = 10'(Y_OFF + 255);
    localparam logic [7:0] X_OFF8   = 8'(X_OFF);
    localparam logic [7:0] Y_OFF8   = 8'(Y_OFF);

    // One slot for the address register plus one per RAM read cycle.
    localparam int DEPTH = 1 + RD_LAT;
    localparam int F_ACT = 0;
    localparam int F_HS  = 1;
    localparam int F_VS  = 2;
    localparam int F_IMG = 3;
    localparam int F_FRM = 4;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [15:0] ram_addr_q;
    logic [4:0]  dly_q [DEPTH];
    logic [4:0]  tail;
    logic [7:0]  pix_q;
    logic        hsync_q, vsync_q, blank_q, frame_q;

    logic        active_s0, hs_s0, vs_s0, in_img_s0, img_en_s0, frame_s0;
    logic [7:0]  h_rel, v_rel;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        active_s0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_s0     = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        vs_s0     = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        in_img_s0 = (h_cnt_q >= X_FIRST) && (h_cnt_q <= X_LAST) &&
                    (v_cnt_q >= Y_FIRST) && (v_cnt_q <= Y_LAST);
        img_en_s0 = in_img_s0 && enable;
        frame_s0  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        h_rel     = h_cnt_q[7:0] - X_OFF8;
        v_rel     = v_cnt_q[7:0] - Y_OFF8;
    end

    assign tail = dly_q[DEPTH-1];

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            ram_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
            pix_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            // Held at zero outside the window so the RAM sees a quiet bus.
            ram_addr_q <= img_en_s0 ? {v_rel, h_rel} : '0;
            dly_q[0]   <= {frame_s0, img_en_s0, vs_s0, hs_s0, active_s0};
            for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
            pix_q      <= (tail[F_IMG] && tail[F_ACT]) ? ram_q : 8'h00;
            hsync_q    <= ~tail[F_HS];
            vsync_q    <= ~tail[F_VS];
            blank_q    <= tail[F_ACT];
            frame_q    <= tail[F_FRM];
        end
    end

    assign ram_addr    = ram_addr_q;
    assign vga_r       = pix_q;
    assign vga_g       = pix_q;
    assign vga_b       = pix_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_q;
    assign frame_start = frame_q;
    assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - bench for vga_frame_reader at read latency 1 and 2
// Vertical timing is shortened so whole frames fit in a short run.
module tb_vga_frame_reader;

    localparam int H_TOT  = 800;
    localparam int V_ACT  = 20;
    localparam int V_FP   = 2;
    localparam int V_SYN  = 2;
    localparam int V_BP   = 3;
    localparam int V_TOT  = V_ACT + V_FP + V_SYN + V_BP;
    localparam int X_OFF  = 192;
    localparam int Y_OFF  = 4;
    localparam int FRAME  = H_TOT * V_TOT;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic        reset  = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] addr1, addr2;
    logic [7:0]  q1, q2a, q2;
    logic [7:0]  r1, g1, b1, r2, g2, b2;
    logic        hs1, vs1, bn1, sn1, fs1;
    logic        hs2, vs2, bn2, sn2, fs2;

    vga_frame_reader #(.V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
                       .Y_OFF(Y_OFF), .RD_LAT(1)) dut1 (
        .vga_clk(vga_clk), .reset(reset), .enable(enable),
        .ram_addr(addr1), .ram_q(q1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .hsync(hs1), .vsync(vs1), .blank_n(bn1), .sync_n(sn1), .frame_start(fs1));

    vga_frame_reader #(.V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
                       .Y_OFF(Y_OFF), .RD_LAT(2)) dut2 (
        .vga_clk(vga_clk), .reset(reset), .enable(enable),
        .ram_addr(addr2), .ram_q(q2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .hsync(hs2), .vsync(vs2), .blank_n(bn2), .sync_n(sn2), .frame_start(fs2));

    // Pixel RAM contents: low address byte XOR high address byte.
    always @(posedge vga_clk) begin
        q1  <= addr1[7:0] ^ addr1[15:8];
        q2a <= addr2[7:0] ^ addr2[15:8];
        q2  <= q2a;
    end

    int checks = 0;
    int errors = 0;
    int t = 0;
    int last_zero = -1;
    bit en_hist [0:65535];
    bit rst_pend;
    int hlow = 0, vlow = 0, prev_fs = -1;
    logic hs1_prev = 1'b1, vs1_prev = 1'b1;
    bit fall_pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic bit in_window(input int h, input int v);
        return h >= X_OFF && h <= X_OFF + 255 && v >= Y_OFF && v <= Y_OFF + 255;
    endfunction

    // {r,g,b, hsync, vsync, blank_n, frame_start} expected lat cycles after the counter value
    function automatic logic [27:0] exp_out(input int tt, input int lat);
        int s, c, h, v;
        logic act;
        logic [7:0] p;
        s = tt - lat;
        if (last_zero > s) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        c = s - last_zero;
        h = c % H_TOT;
        v = (c / H_TOT) % V_TOT;
        act = (h < 640) && (v < V_ACT);
        p = (act && in_window(h, v) && en_hist[s]) ? (8'(h - X_OFF) ^ 8'(v - Y_OFF)) : 8'h00;
        return {p, p, p, !(h >= 656 && h <= 751),
                !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYN), act, (h == 0 && v == 0)};
    endfunction

    function automatic logic [15:0] exp_addr(input int tt);
        int s, c, h, v;
        s = tt - 1;
        if (last_zero > s) return 16'h0;
        c = s - last_zero;
        h = c % H_TOT;
        v = (c / H_TOT) % V_TOT;
        if (en_hist[s] && in_window(h, v)) return {8'(v - Y_OFF), 8'(h - X_OFF)};
        return 16'h0;
    endfunction

    function automatic int cur_h();
        return (t - last_zero) % H_TOT;
    endfunction

    function automatic int cur_v();
        return ((t - last_zero) / H_TOT) % V_TOT;
    endfunction

    task automatic check_all();
        logic [27:0] e;
        e = exp_out(t, 3);
        chk("rgb_lat3", 32'({r1, g1, b1}), 32'(e[27:4]));
        chk("sync_lat3", 32'({hs1, vs1, bn1, fs1}), 32'(e[3:0]));
        chk("addr_lat3", 32'(addr1), 32'(exp_addr(t)));
        e = exp_out(t, 4);
        chk("rgb_lat4", 32'({r2, g2, b2}), 32'(e[27:4]));
        chk("sync_lat4", 32'({hs2, vs2, bn2, fs2}), 32'(e[3:0]));
        chk("addr_lat4", 32'(addr2), 32'(exp_addr(t)));
        chk("sync_n", 32'({sn1, sn2}), 32'(0));

        if (hs1 === 1'b0) begin
            if (hs1_prev === 1'b1 && fall_pending) begin
                chk("hsync_first_fall", 32'(t - last_zero), 32'(659));
                fall_pending = 1'b0;
            end
            hlow++;
        end else begin
            if (hs1_prev === 1'b0) chk("hsync_width", 32'(hlow), 32'(96));
            hlow = 0;
        end
        if (vs1 === 1'b0) vlow++;
        else begin
            if (vs1_prev === 1'b0) chk("vsync_width", 32'(vlow), 32'(2 * H_TOT));
            vlow = 0;
        end
        if (fs1 === 1'b1) begin
            if (prev_fs > last_zero) chk("frame_period", 32'(t - prev_fs), 32'(FRAME));
            else chk("frame_first", 32'(t - last_zero), 32'(3));
            prev_fs = t;
        end
        hs1_prev = hs1;
        vs1_prev = vs1;
    endtask

    task automatic step();
        en_hist[t] = enable;
        rst_pend = reset;
        @(posedge vga_clk);
        t++;
        if (rst_pend) begin
            last_zero = t;
            fall_pending = 1'b1;
        end
        #1;
        if (last_zero >= 0) check_all();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        repeat (FRAME) step();

        repeat (FRAME) begin
            enable = !(cur_v() >= 8 && cur_v() <= 17);
            step();
        end

        while (!(cur_h() == 400 && cur_v() == 10)) begin
            enable = ($urandom_range(0, 3) != 0);
            step();
        end

        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2000) begin
            enable = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
